// File: rtl/tc_pl_cap_gain_seq.sv
// Multi-gain capture sweep sequencer.
// Walks the enabled gains lowest index first: load the gain selection, let the
// datapath settle, kick the capture engine and wait for its completion or a
// timeout. Every output is registered and decoded from the next state, so an
// output is valid in the same cycle as the state it belongs to.
module tc_pl_cap_gain_seq #(
  parameter int CAP0_1   = 3,
  parameter int SETTLE_W = 16,
  parameter int TMO_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          gain_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [TMO_W-1:0]    timeout_cycles,
  input  logic                cap_done,
  output logic [CAP0_1-2:0]   gain_value,
  output logic                gain_en,
  output logic                cap_start,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [3:0]          gain_done_mask
);

  localparam int GW = CAP0_1 - 1;   // gain index width
  localparam int NG = 1 << GW;      // number of gains

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        idx, idx_nxt;
  logic [SETTLE_W-1:0]  scnt, scnt_nxt;
  logic [TMO_W-1:0]     tcnt, tcnt_nxt;
  logic [NG-1:0]        lmask, lmask_nxt;
  logic [SETTLE_W-1:0]  lsettle, lsettle_nxt;
  logic [TMO_W-1:0]     ltmo, ltmo_nxt;
  logic                 err_nxt;
  logic [NG-1:0]        dmask_nxt;
  logic [GW:0]          found;

  // Lowest set bit of m at index >= from; MSB of the result flags a hit.
  function automatic logic [GW:0] find_from(input logic [NG-1:0] m, input logic [GW:0] from);
    logic [GW:0] r;
    r = {1'b0, {GW{1'b0}}};
    for (int i = NG - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && m[i]) begin
        r = {1'b1, i[GW-1:0]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state, counter and latched-copy logic; abort overrides everything.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    scnt_nxt    = scnt;
    tcnt_nxt    = tcnt;
    lmask_nxt   = lmask;
    lsettle_nxt = lsettle;
    ltmo_nxt    = ltmo;
    err_nxt     = err_timeout;
    dmask_nxt   = gain_done_mask;
    found       = {(GW+1){1'b0}};
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lmask_nxt   = gain_mask;
            lsettle_nxt = settle_cycles;
            ltmo_nxt    = timeout_cycles;
            err_nxt     = 1'b0;
            dmask_nxt   = {NG{1'b0}};
            if (gain_mask == {NG{1'b0}}) begin
              state_nxt = FINISH;
            end else begin
              found     = find_from(gain_mask, {(GW+1){1'b0}});
              idx_nxt   = found[GW-1:0];
              state_nxt = SELECT;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        SELECT: begin
          scnt_nxt  = lsettle;
          state_nxt = SETTLE;
        end
        SETTLE: begin
          if (scnt == {SETTLE_W{1'b0}}) begin
            state_nxt = START;
          end else begin
            scnt_nxt = scnt - SETTLE_W'(1);
          end
        end
        START: begin
          tcnt_nxt  = ltmo;
          state_nxt = WAIT;
        end
        WAIT: begin
          // completion beats a coincident timeout expiry
          if (cap_done) begin
            dmask_nxt[idx] = 1'b1;
            state_nxt      = NEXT;
          end else if ((ltmo != {TMO_W{1'b0}}) && (tcnt <= TMO_W'(1))) begin
            err_nxt   = 1'b1;
            state_nxt = FINISH;
          end else if (tcnt != {TMO_W{1'b0}}) begin
            tcnt_nxt = tcnt - TMO_W'(1);
          end else begin
            tcnt_nxt = tcnt;
          end
        end
        NEXT: begin
          found = find_from(lmask, {1'b0, idx} + (GW+1)'(1));
          if (found[GW]) begin
            idx_nxt   = found[GW-1:0];
            state_nxt = SELECT;
          end else begin
            state_nxt = FINISH;
          end
        end
        FINISH: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counters, latched copies and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= {GW{1'b0}};
      scnt           <= {SETTLE_W{1'b0}};
      tcnt           <= {TMO_W{1'b0}};
      lmask          <= {NG{1'b0}};
      lsettle        <= {SETTLE_W{1'b0}};
      ltmo           <= {TMO_W{1'b0}};
      gain_value     <= {GW{1'b0}};
      gain_en        <= 1'b0;
      cap_start      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      gain_done_mask <= {NG{1'b0}};
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      scnt           <= scnt_nxt;
      tcnt           <= tcnt_nxt;
      lmask          <= lmask_nxt;
      lsettle        <= lsettle_nxt;
      ltmo           <= ltmo_nxt;
      gain_value     <= (state_nxt == SELECT) ? idx_nxt : gain_value;
      gain_en        <= (state_nxt == SELECT);
      cap_start      <= (state_nxt == START);
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == FINISH);
      err_timeout    <= err_nxt;
      gain_done_mask <= dmask_nxt;
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_gain_seq.sv
// Self-checking bench for tc_pl_cap_gain_seq. A transaction-level model turns
// (mask, settle, timeout, per-capture response delay, abort cycle) into the
// expected cycle of every gain load, capture start, completion and done pulse.
module tb_tc_pl_cap_gain_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  gain_mask;
  logic [15:0] settle_cycles;
  logic [23:0] timeout_cycles;
  logic        cap_done;
  logic [1:0]  gain_value;
  logic        gain_en;
  logic        cap_start;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [3:0]  gain_done_mask;

  tc_pl_cap_gain_seq #(.CAP0_1(3), .SETTLE_W(16), .TMO_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gain_mask(gain_mask), .settle_cycles(settle_cycles),
    .timeout_cycles(timeout_cycles), .cap_done(cap_done),
    .gain_value(gain_value), .gain_en(gain_en), .cap_start(cap_start),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .gain_done_mask(gain_done_mask)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // response delay per capture ordinal (cycles after cap_start), 0 = never
  int resp_dly [4];

  // model results
  int exp_sel [4];
  int exp_gval [4];
  int exp_cs [4];
  int bit_set_cycle [4];
  int n_sel;
  int exp_finish;
  bit exp_err;
  int model_gval;

  // observations of the last sweep
  int         got_caps;
  int         got_gen;
  int         got_done;
  logic [7:0] got_gv_seq;

  // Cycle 0 is the edge that samples start; SELECT of the first gain is cycle 1.
  task automatic model(input logic [3:0] m, input int s, input int tmo);
    int t, cs, d;
    bit timed;
    t = 0; n_sel = 0; timed = 1'b0; exp_finish = 0;
    for (int g = 0; g < 4; g++) bit_set_cycle[g] = 1 << 30;
    for (int g = 0; g < 4; g++) begin
      if (m[g] && !timed) begin
        exp_sel[n_sel]  = t + 1;
        exp_gval[n_sel] = g;
        cs = t + 1 + s + 2;
        exp_cs[n_sel]   = cs;
        d = resp_dly[n_sel];
        n_sel++;
        if (d != 0 && (tmo == 0 || d <= tmo)) begin
          bit_set_cycle[g] = cs + d + 1;
          t = cs + d + 1;
        end else begin
          timed = 1'b1;
          exp_finish = cs + tmo + 1;
        end
      end
    end
    if (!timed) exp_finish = t + 1;
    exp_err = timed;
  endtask

  task automatic run_sweep(input logic [3:0] m, input int s, input int tmo,
                           input int abort_cyc, input bit noise, input bit start_at_abort);
    int k, sched, end_c;
    bit live, e_gen, e_cs, e_busy, e_done, e_err;
    logic [3:0] e_dm;
    model(m, s, tmo);
    end_c = (abort_cyc > 0) ? abort_cyc : exp_finish;
    gain_mask = m; settle_cycles = s[15:0]; timeout_cycles = tmo[23:0];
    start = 1'b1; abort = 1'b0; cap_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    gain_mask = 4'($urandom); settle_cycles = 16'($urandom_range(0, 20));
    timeout_cycles = 24'($urandom_range(0, 3));
    k = 0; sched = -1; got_caps = 0; got_gen = 0; got_done = 0; got_gv_seq = 8'h00;
    for (int c = 1; c <= end_c + 4; c++) begin
      live = (abort_cyc == 0) || (c <= abort_cyc);
      e_gen = 1'b0; e_cs = 1'b0;
      for (int i = 0; i < n_sel; i++) begin
        if (live && exp_sel[i] == c) begin e_gen = 1'b1; model_gval = exp_gval[i]; end
        if (live && exp_cs[i] == c) e_cs = 1'b1;
      end
      e_busy = live && (c <= exp_finish);
      e_done = live && (c == exp_finish);
      e_err  = exp_err && (c >= exp_finish) && (abort_cyc == 0 || exp_finish <= abort_cyc);
      for (int g = 0; g < 4; g++)
        e_dm[g] = (bit_set_cycle[g] <= c) && (abort_cyc == 0 || bit_set_cycle[g] <= abort_cyc);

      vectors++;
      if (gain_en !== e_gen) begin miscompares++; $display("FAIL gain_en @%0d: got %0b expected %0b", c, gain_en, e_gen); end
      vectors++;
      if (gain_value !== 2'(model_gval)) begin miscompares++; $display("FAIL gain_value @%0d: got %0d expected %0d", c, gain_value, model_gval); end
      vectors++;
      if (cap_start !== e_cs) begin miscompares++; $display("FAIL cap_start @%0d: got %0b expected %0b", c, cap_start, e_cs); end
      vectors++;
      if (busy !== e_busy) begin miscompares++; $display("FAIL busy @%0d: got %0b expected %0b", c, busy, e_busy); end
      vectors++;
      if (done !== e_done) begin miscompares++; $display("FAIL done @%0d: got %0b expected %0b", c, done, e_done); end
      vectors++;
      if (err_timeout !== e_err) begin miscompares++; $display("FAIL err_timeout @%0d: got %0b expected %0b", c, err_timeout, e_err); end
      vectors++;
      if (gain_done_mask !== e_dm) begin miscompares++; $display("FAIL gain_done_mask @%0d: got %b expected %b", c, gain_done_mask, e_dm); end

      if (cap_start === 1'b1) begin
        got_caps++;
        sched = (k < 4 && resp_dly[k] != 0) ? c + resp_dly[k] : -1;
        k++;
      end
      if (gain_en === 1'b1) begin got_gen++; got_gv_seq = {got_gv_seq[5:0], gain_value}; end
      if (done === 1'b1) got_done++;

      // inputs for cycle c: responder, stray completions outside WAIT, stray starts
      cap_done = (c == sched) || (c == end_c + 2) || (noise && e_gen);
      start = (noise && c <= end_c && $urandom_range(0, 3) == 0) ||
              (start_at_abort && c == abort_cyc);
      abort = (abort_cyc > 0) && (c == abort_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; cap_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cap_done = 1'b0;
    gain_mask = 4'h0; settle_cycles = 16'd0; timeout_cycles = 24'd0;
    model_gval = 0;
    #12;
    vectors++;
    if ({gain_value, gain_en, cap_start, busy, done, err_timeout, gain_done_mask} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {gain_value, gain_en, cap_start, busy, done, err_timeout, gain_done_mask});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got busy %0b expected 0", busy); end
  endtask

  task automatic test_single_gain;
    resp_dly = '{3, 3, 3, 3};
    run_sweep(4'b0001, 2, 0, 0, 1'b0, 1'b0);
    vectors++;
    if (got_caps !== 1) begin miscompares++; $display("FAIL single_caps: got %0d expected 1", got_caps); end
    vectors++;
    if (got_done !== 1) begin miscompares++; $display("FAIL single_done: got %0d expected 1", got_done); end
    vectors++;
    if (gain_done_mask !== 4'b0001) begin miscompares++; $display("FAIL single_mask: got %b expected 0001", gain_done_mask); end
  endtask

  task automatic test_sparse;
    resp_dly = '{3, 3, 3, 3};
    run_sweep(4'b1010, 0, 0, 0, 1'b1, 1'b0);
    vectors++;
    if (got_caps !== 2) begin miscompares++; $display("FAIL sparse_caps: got %0d expected 2", got_caps); end
    vectors++;
    if (got_gen !== 2 || got_gv_seq[3:0] !== 4'b0111) begin
      miscompares++; $display("FAIL sparse_gains: got %0d loads seq %b expected 2 loads seq 0111", got_gen, got_gv_seq[3:0]);
    end
    vectors++;
    if (got_done !== 1) begin miscompares++; $display("FAIL sparse_done: got %0d expected 1", got_done); end
    vectors++;
    if (gain_done_mask !== 4'b1010) begin miscompares++; $display("FAIL sparse_mask: got %b expected 1010", gain_done_mask); end
  endtask

  task automatic test_timeout;
    resp_dly = '{0, 0, 0, 0};
    run_sweep(4'b0011, 1, 10, 0, 1'b0, 1'b0);
    vectors++;
    if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %0b expected 1", err_timeout); end
    vectors++;
    if (got_gen !== 1) begin miscompares++; $display("FAIL timeout_loads: got %0d expected 1", got_gen); end
    vectors++;
    if (gain_done_mask !== 4'b0000) begin miscompares++; $display("FAIL timeout_mask: got %b expected 0000", gain_done_mask); end
    // next sweep must clear the sticky error
    resp_dly = '{2, 2, 2, 2};
    run_sweep(4'b0100, 1, 0, 0, 1'b0, 1'b0);
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %0b expected 0", err_timeout); end
  endtask

  task automatic test_empty_mask;
    run_sweep(4'b0000, 3, 0, 0, 1'b0, 1'b0);
    vectors++;
    if (got_gen !== 0 || got_caps !== 0) begin
      miscompares++; $display("FAIL empty_pulses: got %0d loads %0d starts expected 0 0", got_gen, got_caps);
    end
    vectors++;
    if (got_done !== 1) begin miscompares++; $display("FAIL empty_done: got %0d expected 1", got_done); end
  endtask

  task automatic test_abort;
    // gains 0 and 1 complete; abort lands in gain 2's settle window (cycles 20..23)
    resp_dly = '{2, 2, 2, 2};
    run_sweep(4'b0111, 3, 0, 21, 1'b0, 1'b1);
    vectors++;
    if (got_caps !== 2) begin miscompares++; $display("FAIL abort_caps: got %0d expected 2", got_caps); end
    vectors++;
    if (got_done !== 0) begin miscompares++; $display("FAIL abort_done: got %0d expected 0", got_done); end
    vectors++;
    if (gain_done_mask !== 4'b0011 || busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_hold: got mask %b busy %0b expected 0011 0", gain_done_mask, busy);
    end
  endtask

  task automatic test_timeout_boundary;
    resp_dly = '{5, 5, 5, 5};
    run_sweep(4'b0001, 0, 5, 0, 1'b1, 1'b0);
    vectors++;
    if (err_timeout !== 1'b0 || gain_done_mask !== 4'b0001) begin
      miscompares++; $display("FAIL edge_success: got err %0b mask %b expected 0 0001", err_timeout, gain_done_mask);
    end
    resp_dly = '{6, 6, 6, 6};
    run_sweep(4'b0001, 0, 5, 0, 1'b0, 1'b0);
    vectors++;
    if (err_timeout !== 1'b1 || gain_done_mask !== 4'b0000) begin
      miscompares++; $display("FAIL edge_late: got err %0b mask %b expected 1 0000", err_timeout, gain_done_mask);
    end
  endtask

  task automatic test_random;
    logic [3:0] m;
    int s, tmo, ab;
    for (int n = 0; n < 40; n++) begin
      m = 4'($urandom_range(0, 15));
      s = $urandom_range(0, 4);
      tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
      for (int i = 0; i < 4; i++)
        resp_dly[i] = (tmo != 0 && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 10);
      model(m, s, tmo);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_finish) : 0;
      run_sweep(m, s, tmo, ab, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_wait;
    resp_dly = '{0, 0, 0, 0};
    gain_mask = 4'b0100; settle_cycles = 16'd0; timeout_cycles = 24'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    vectors++;
    if (busy !== 1'b1 || gain_value !== 2'd2) begin
      miscompares++; $display("FAIL rst_pre: got busy %0b gain %0d expected 1 2", busy, gain_value);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({gain_value, gain_en, cap_start, busy, done, err_timeout, gain_done_mask} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got %b expected all zero",
               {gain_value, gain_en, cap_start, busy, done, err_timeout, gain_done_mask});
    end
    @(negedge clk);
    rst = 1'b0;
    model_gval = 0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL rst_after: got busy %0b done %0b expected 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset;
    test_single_gain;
    test_sparse;
    test_timeout;
    test_empty_mask;
    test_abort;
    test_timeout_boundary;
    test_random;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
